// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath width and the execute-stage mult/div opcode.
// The decode and hazard logic use the same enum.
package mips_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } op_e;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider core: one quotient bit per clock, WIDTH clocks per divide.
// quotient/remainder carry the result of the current step and are final when last=1.
module serial_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] dvs_reg;
   logic [CW-1:0]    count_reg;
   logic             run_reg;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // quo_reg doubles as the dividend shift register; a quotient bit enters as a dividend bit leaves.
   always_comb begin
      shifted   = {rem_reg, quo_reg[WIDTH-1]};
      diff      = shifted - {1'b0, dvs_reg};
      remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quotient  = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
      busy      = run_reg;
      last      = run_reg && (count_reg == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         count_reg <= '0;
         run_reg   <= 1'b0;
      end else if (abort) begin
         run_reg <= 1'b0;
      end else if (start) begin
         rem_reg   <= '0;
         quo_reg   <= dividend;
         dvs_reg   <= divisor;
         count_reg <= '0;
         run_reg   <= 1'b1;
      end else if (run_reg) begin
         rem_reg   <= remainder;
         quo_reg   <= quotient;
         count_reg <= count_reg + CW'(1);
         if (last) run_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, serial DIV/DIVU with sign fix-up.
// busy stalls the pipeline while a division runs; done pulses once when HI/LO are written.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start_execute,
   input  logic [2:0]       op_execute,
   input  logic [WIDTH-1:0] Rs_value_execute,
   input  logic [WIDTH-1:0] Rt_value_execute,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_DIV  = 1'b1;

   logic [0:0]         state_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic               done_reg, q_neg_reg, r_neg_reg;
   logic               accept, is_div, signed_div, rs_neg, rt_neg, div_start;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic               div_busy, div_last;
   logic [WIDTH-1:0]   div_q, div_r;

   always_comb begin
      accept     = (state_reg == S_IDLE) && start_execute && !clear;
      is_div     = (op_e'(op_execute) == OP_DIV) || (op_e'(op_execute) == OP_DIVU);
      signed_div = (op_e'(op_execute) == OP_DIV);
      rs_neg     = signed_div && Rs_value_execute[WIDTH-1];
      rt_neg     = signed_div && Rt_value_execute[WIDTH-1];
      rs_mag     = rs_neg ? -Rs_value_execute : Rs_value_execute;
      rt_mag     = rt_neg ? -Rt_value_execute : Rt_value_execute;
      div_start  = accept && is_div && (Rt_value_execute != '0);
      // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
      prod_s = {{WIDTH{Rs_value_execute[WIDTH-1]}}, Rs_value_execute}
             * {{WIDTH{Rt_value_execute[WIDTH-1]}}, Rt_value_execute};
      prod_u = {{WIDTH{1'b0}}, Rs_value_execute} * {{WIDTH{1'b0}}, Rt_value_execute};
   end

   serial_divider #(.WIDTH(WIDTH)) u_divider (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .abort     (clear),
      .dividend  (rs_mag),
      .divisor   (rt_mag),
      .busy      (div_busy),
      .last      (div_last),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         hi_reg    <= '0;
         lo_reg    <= '0;
         done_reg  <= 1'b0;
         q_neg_reg <= 1'b0;
         r_neg_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: if (accept) begin
               case (op_e'(op_execute))
                  OP_MULT:  {hi_reg, lo_reg} <= prod_s;
                  OP_MULTU: {hi_reg, lo_reg} <= prod_u;
                  OP_MTHI:  hi_reg <= Rs_value_execute;
                  OP_MTLO:  lo_reg <= Rs_value_execute;
                  OP_DIV, OP_DIVU: begin
                     if (Rt_value_execute == '0) begin
                        lo_reg   <= '1;
                        hi_reg   <= Rs_value_execute;
                        done_reg <= 1'b1;
                     end else begin
                        q_neg_reg <= rs_neg ^ rt_neg;
                        r_neg_reg <= rs_neg;
                        state_reg <= S_DIV;
                     end
                  end
                  default: ;
               endcase
            end
            S_DIV: begin
               if (clear) begin
                  state_reg <= S_IDLE;
               end else if (div_last) begin
                  hi_reg    <= r_neg_reg ? -div_r : div_r;
                  lo_reg    <= q_neg_reg ? -div_q : div_q;
                  done_reg  <= 1'b1;
                  state_reg <= S_IDLE;
               end else if (!div_busy) begin
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign hi   = hi_reg;
   assign lo   = lo_reg;
   assign busy = (state_reg == S_DIV);
   assign done = done_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO pushed to a scoreboard when a
// command is driven, popped and compared when the unit produces its result.
module tb_mult_div_unit;
   import mips_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   logic        clk, reset, clear, start_execute;
   logic [2:0]  op_execute;
   logic [31:0] rs, rt, hi, lo;
   logic        busy, done;

   res_t sb[$];
   res_t exp_r;
   int   checks = 0;
   int   errors = 0;

   mult_div_unit dut (
      .clk              (clk),
      .reset            (reset),
      .clear            (clear),
      .start_execute    (start_execute),
      .op_execute       (op_execute),
      .Rs_value_execute (rs),
      .Rt_value_execute (rt),
      .hi               (hi),
      .lo               (lo),
      .busy             (busy),
      .done             (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic res_t div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      res_t r;
      if (b == 32'd0) begin
         r.lo = 32'hFFFF_FFFF;
         r.hi = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r.lo = 32'h8000_0000;
         r.hi = 32'h0;
      end else if (sgn) begin
         r.lo = 32'($signed(a) / $signed(b));
         r.hi = 32'($signed(a) % $signed(b));
      end else begin
         r.lo = a / b;
         r.hi = a % b;
      end
      return r;
   endfunction

   // Drives one command for one edge; returns at the negedge after the accepting edge.
   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_execute = 1'b1;
      op_execute    = op;
      rs            = a;
      rt            = b;
      @(negedge clk);
      start_execute = 1'b0;
      op_execute    = 3'd0;
      $display("txn op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%b done=%b", op, a, b, hi, lo, busy, done);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      clear = 1'b0;
      start_execute = 1'b0;
      op_execute = 3'd0;
      rs = '0;
      rt = '0;
      #3;
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_mult;
      logic [31:0] a, b;
      int busy_seen = 0;
      sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE});
      drive(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
      if (busy) busy_seen++;
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL mult_signed got %h_%h want %h", hi, lo, exp_r); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done got %b want 0", done); end
      sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE});
      drive(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      if (busy) busy_seen++;
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL multu got %h_%h want %h", hi, lo, exp_r); end
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         if (i[0]) sb.push_back(res_t'(64'(a) * 64'(b)));
         else      sb.push_back(res_t'(64'(longint'($signed(a)) * longint'($signed(b)))));
         drive(i[0] ? OP_MULTU : OP_MULT, a, b);
         if (busy) busy_seen++;
         exp_r = sb.pop_front();
         checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL mult_rand%0d got %h_%h want %h", i, hi, lo, exp_r); end
      end
      checks++; if (busy_seen != 0) begin errors++; $display("FAIL mult_busy seen %0d times want 0", busy_seen); end
   endtask

   task automatic test_mt;
      sb.push_back('{hi: 32'hA5A5_0001, lo: lo});
      drive(OP_MTHI, 32'hA5A5_0001, 32'h0);
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL mthi got %h_%h want %h", hi, lo, exp_r); end
      sb.push_back('{hi: 32'hA5A5_0001, lo: 32'h5A5A_0002});
      drive(OP_MTLO, 32'h5A5A_0002, 32'h0);
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL mtlo got %h_%h want %h", hi, lo, exp_r); end
   endtask

   // Runs one division to completion: checks busy length, done pulse and result.
   task automatic run_div(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input res_t expv);
      int cycles = 0;
      sb.push_back(expv);
      drive(op, a, b);
      for (int i = 0; i < 100 && busy === 1'b1; i++) begin
         cycles++;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_early at busy cycle %0d", name, cycles); end
         @(negedge clk);
      end
      exp_r = sb.pop_front();
      checks++; if (cycles != ((b == 32'd0) ? 0 : 32)) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, cycles, (b == 32'd0) ? 0 : 32); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done got %b want 1", name, done); end
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL %s result got %h_%h want %h", name, hi, lo, exp_r); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", name, done); end
      $display("txn %s done hi=%h lo=%h cycles=%0d", name, hi, lo, cycles);
   endtask

   task automatic test_div;
      logic [31:0] a, b;
      logic        sgn;
      run_div("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
      run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14});
      run_div("div_by_zero", OP_DIV, 32'd5, 32'd0, '{hi: 32'd5, lo: 32'hFFFF_FFFF});
      run_div("divu_by_zero", OP_DIVU, 32'h8000_0001, 32'd0, '{hi: 32'h8000_0001, lo: 32'hFFFF_FFFF});
      run_div("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'h0, lo: 32'h8000_0000});
      run_div("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, '{hi: 32'd1, lo: 32'hFFFF_FFFD});
      run_div("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, '{hi: 32'd0, lo: 32'hFFFF_FFFF});
      for (int i = 0; i < 6; i++) begin
         a   = $urandom;
         b   = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         sgn = i[0];
         run_div("div_rand", sgn ? 3'(OP_DIV) : 3'(OP_DIVU), a, b, div_model(sgn, a, b));
      end
   endtask

   task automatic test_clear;
      int done_seen = 0;
      res_t prior;
      prior = {hi, lo};
      drive(OP_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", busy); end
      checks++; if ({hi, lo} !== prior) begin errors++; $display("FAIL clear_hilo got %h_%h want %h", hi, lo, prior); end
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL clear_done seen %0d want 0", done_seen); end
      // Commands during busy are ignored; the division result stands.
      sb.push_back('{hi: 32'd2, lo: 32'd14});
      drive(OP_DIVU, 32'd100, 32'd7);
      drive(OP_MULT, 32'd3, 32'd5);
      drive(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
      for (int i = 0; i < 100 && busy === 1'b1; i++) @(negedge clk);
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL busy_ignore got %h_%h want %h", hi, lo, exp_r); end
      // clear concurrent with start in IDLE drops the command.
      prior = {hi, lo};
      clear = 1'b1;
      drive(OP_MULT, 32'd3, 32'd5);
      clear = 1'b0;
      checks++; if ({hi, lo} !== prior) begin errors++; $display("FAIL clear_start got %h_%h want %h", hi, lo, prior); end
   endtask

   task automatic test_back_to_back;
      sb.push_back('{hi: 32'd2, lo: 32'd14});
      drive(OP_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL b2b_div got %h_%h want %h", hi, lo, exp_r); end
      sb.push_back('{hi: 32'd0, lo: 32'd15});
      start_execute = 1'b1;
      op_execute    = OP_MULTU;
      rs            = 32'd3;
      rt            = 32'd5;
      @(negedge clk);
      start_execute = 1'b0;
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL b2b_mult got %h_%h want %h", hi, lo, exp_r); end
      $display("txn b2b multu hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_async_reset;
      int done_seen = 0;
      drive(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL areset_hilo got %h_%h want 0", hi, lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) done_seen++;
         @(negedge clk);
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL areset_residue seen %0d want 0", done_seen); end
      sb.push_back('{hi: 32'h0, lo: 32'h1234_5678});
      drive(OP_MTLO, 32'h1234_5678, 32'h0);
      exp_r = sb.pop_front();
      checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL areset_mtlo got %h_%h want %h", hi, lo, exp_r); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_mt();
      test_div();
      test_clear();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (reset=0 asserts).
REQ-004 clear  input  1  synchronous abort of any in-flight division.
REQ-005 start_execute  input  1  op_execute is valid this cycle.
REQ-006 op_execute  input  3  NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
REQ-007 Rs_value_execute  input  32  multiplicand / dividend / MTHI-MTLO source.
REQ-008 Rt_value_execute  input  32  multiplier / divisor.
REQ-009 hi  output  32  HI register.
REQ-010 lo  output  32  LO register.
REQ-011 busy  output  1  division in progress; stall request to hazard unit.
REQ-012 done  output  1  one-cycle pulse after a division writes HI/LO.

Function
REQ-013 FSM states: IDLE, DIV; no other states.
REQ-014 Commands are accepted only in IDLE with start_execute=1 and clear=0; otherwise ignored (including MTHI/MTLO while busy).
REQ-015 MULT/MULTU: at the accepting edge, {hi,lo} <= 64-bit signed/unsigned product; no busy, no done.
REQ-016 MTHI/MTLO: at the accepting edge, hi (resp. lo) <= Rs_value_execute; other register unchanged.
REQ-017 DIV/DIVU, Rt nonzero: accepting edge N latches operand magnitudes, sign flags, iteration count 0, state -> DIV.
REQ-018 Restoring division, one quotient bit per edge, edges N+1..N+32; at edge N+32 hi <= remainder, lo <= quotient, state -> IDLE.
REQ-019 busy=1 exactly while state==DIV (32 cycles); registered, not derived from inputs.
REQ-020 done=1 for exactly the one cycle following edge N+32.
REQ-021 Signed rules: quotient negated when signs of Rs and Rt differ; remainder takes sign of Rs; truncation toward zero.
REQ-022 Overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-023 Divide by zero (Rt=0), DIV or DIVU: at the accepting edge lo <= 0xFFFFFFFF, hi <= Rs_value_execute; busy stays 0; done pulses next cycle.
REQ-024 clear=1 during DIV: state -> IDLE at that edge, hi/lo unchanged, no done pulse; busy low next cycle.
REQ-025 clear=1 concurrent with start_execute in IDLE: command dropped.
REQ-026 hi/lo change only per REQ-015/016/018/023 or reset.

Reset
REQ-027 reset=0 immediately forces state=IDLE, hi=0, lo=0, busy=0, done=0, iteration count=0, independent of clk.
REQ-028 Reset during DIV discards the division; no done after release.
REQ-029 First command accepted on the first rising edge after reset returns to 1.

Structure
REQ-030 Shared package mips_pkg holds the op_execute enum and WIDTH constant; decode and hazard logic import the same enum.
REQ-031 One sub-module serial_divider (unsigned restoring core: start, operands, busy, quotient, remainder); sign fix-up, multiply and HI/LO registers stay in mult_div_unit.

Verification
REQ-032 MULT Rs=0xFFFFFFFF Rt=0x00000002 -> hi=0xFFFFFFFF lo=0xFFFFFFFE after one edge; MULTU same operands -> hi=0x00000001 lo=0xFFFFFFFE; busy never high.
REQ-033 DIV Rs=0xFFFFFFF9 (-7) Rt=2 -> busy high 32 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done single pulse; DIVU Rs=100 Rt=7 -> lo=14, hi=2.
REQ-034 DIV Rs=5 Rt=0 -> lo=0xFFFFFFFF hi=5 after one edge, busy=0; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-035 DIVU 100/7 with clear at cycle 10 of busy -> busy low next cycle, hi/lo retain prior values, no done; MULT issued while busy -> ignored.
REQ-036 reset=0 asserted between clock edges mid-division -> hi=lo=0, busy=0 before next edge; MTLO 0x12345678 after release -> lo=0x12345678, hi=0.
